// File: rtl/wr_resp_direction_router.sv
// wr_resp_direction_router: routes accepted write requests into per-direction
// response FIFOs selected by cmd_txnid.direction_id.
//   clk, rst_n           clock, asynchronous active-low reset
//   req_vld/req_rdy      request handshake; req_pld carries opcode, txnid, sideband
//   v_wresp_vld/rdy/pld  per-direction response handshake and head-of-queue payload
//   v_wresp_cnt          per-direction queue occupancy
//   err_bad_dir          sticky: a write with an out-of-range direction was accepted
`ifndef CMD_WRITE
`define CMD_WRITE 2'b01
`endif

package wr_resp_direction_router_pkg;
    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = `CMD_WRITE;
    typedef struct packed {
        logic [1:0] direction_id;
        logic [5:0] id;
    } txnid_t;
    typedef struct packed {
        logic [1:0] cmd_opcode;
        txnid_t     cmd_txnid;
        logic [3:0] cmd_sideband;
    } input_req_pld_t;
    typedef struct packed {
        txnid_t     txnid;
        logic [3:0] sideband;
    } wr_resp_pld_t;
endpackage

module wr_resp_direction_router
    import wr_resp_direction_router_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   req_vld,
    output logic                                   req_rdy,
    input  input_req_pld_t                         req_pld,
    output logic [WIDTH-1:0]                       v_wresp_vld,
    input  logic [WIDTH-1:0]                       v_wresp_rdy,
    output wr_resp_pld_t                           v_wresp_pld [WIDTH],
    output logic [WIDTH-1:0][$clog2(DEPTH+1)-1:0]  v_wresp_cnt,
    output logic                                   err_bad_dir
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]       dir;
    logic             is_wr, dir_ok, acc_wr;
    logic [WIDTH-1:0] full;
    logic [3:0]       full_x;
    wr_resp_pld_t     push_pld;

    assign dir      = req_pld.cmd_txnid.direction_id;
    assign is_wr    = req_pld.cmd_opcode == CMD_WRITE;
    assign dir_ok   = 32'(dir) < 32'(WIDTH);
    // Widened so every 2-bit direction indexes a defined bit; out-of-range directions never stall.
    assign full_x   = 4'(full);
    // Stall decision uses registered occupancy only, so a same-cycle pop cannot open it.
    assign req_rdy  = !(is_wr && dir_ok && full_x[dir]);
    assign acc_wr   = req_vld && req_rdy && is_wr;
    assign push_pld = {req_pld.cmd_txnid, req_pld.cmd_sideband};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err_bad_dir <= 1'b0;
        else if (acc_wr && !dir_ok) err_bad_dir <= 1'b1;

    for (genvar g = 0; g < WIDTH; g++) begin : g_dir
        logic [AW-1:0] wp, rp;
        logic [CW-1:0] cnt;
        logic          push, pop;
        wr_resp_pld_t  mem [DEPTH];
        assign push = acc_wr && dir_ok && dir == 2'(g);
        assign pop  = v_wresp_vld[g] && v_wresp_rdy[g];
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop) rp <= rp + 1'b1;
                cnt <= cnt + CW'(push) - CW'(pop);
            end
        always_ff @(posedge clk)
            if (push) mem[wp] <= push_pld;
        assign v_wresp_vld[g] = cnt != '0;
        assign v_wresp_pld[g] = mem[rp];
        assign v_wresp_cnt[g] = cnt;
        assign full[g]        = cnt == CW'(DEPTH);
    end
endmodule

// File: tb/tb_wr_resp_direction_router.sv
// tb_wr_resp_direction_router: self-checking bench with a queue-based reference model.
module tb_wr_resp_direction_router;
    import wr_resp_direction_router_pkg::*;
    localparam int W = 4, D = 4, CW = 3;

    logic clk = 1'b0, rst_n = 1'b1, req_vld = 1'b0;
    input_req_pld_t req_pld = '0;
    logic [W-1:0] rdy = '0;
    logic req_rdy, err;
    logic [W-1:0] vld;
    wr_resp_pld_t pld [W];
    logic [W-1:0][CW-1:0] cnt;
    logic [2:0] rdy3 = '1;
    logic req_rdy3, err3;
    logic [2:0] vld3;
    wr_resp_pld_t pld3 [3];
    logic [2:0][CW-1:0] cnt3;

    int n_cmp = 0, n_bad = 0;
    wr_resp_pld_t mq [W][$];
    logic m_err = 1'b0;

    always #5 clk = ~clk;

    wr_resp_direction_router #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy), .req_pld(req_pld),
        .v_wresp_vld(vld), .v_wresp_rdy(rdy), .v_wresp_pld(pld), .v_wresp_cnt(cnt),
        .err_bad_dir(err)
    );

    wr_resp_direction_router #(.WIDTH(3), .DEPTH(D)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy3), .req_pld(req_pld),
        .v_wresp_vld(vld3), .v_wresp_rdy(rdy3), .v_wresp_pld(pld3), .v_wresp_cnt(cnt3),
        .err_bad_dir(err3)
    );

    function automatic logic m_rdy(input input_req_pld_t p);
        int d;
        d = int'(p.cmd_txnid.direction_id);
        return !(p.cmd_opcode == CMD_WRITE && d < W && mq[d].size() == D);
    endfunction

    function automatic logic [W-1:0] m_vld();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = mq[i].size() != 0;
        return v;
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] d);
        req_vld = v;
        req_pld.cmd_opcode = op;
        req_pld.cmd_txnid.direction_id = d;
        req_pld.cmd_txnid.id = 6'($urandom);
        req_pld.cmd_sideband = 4'($urandom);
    endtask

    task automatic tick();
        input_req_pld_t p;
        logic acc;
        logic [W-1:0] pop;
        wr_resp_pld_t e;
        p = req_pld;
        acc = req_vld && m_rdy(p);
        pop = m_vld() & rdy;
        @(posedge clk);
        for (int i = 0; i < W; i++) if (pop[i]) void'(mq[i].pop_front());
        if (acc && p.cmd_opcode == CMD_WRITE) begin
            e.txnid = p.cmd_txnid;
            e.sideband = p.cmd_sideband;
            if (int'(p.cmd_txnid.direction_id) < W) mq[p.cmd_txnid.direction_id].push_back(e);
            else m_err = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_vld = 1'b0;
        for (int i = 0; i < W; i++) mq[i].delete();
        m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, CMD_WRITE, 2'd0);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (vld !== '0) begin n_bad++; $display("FAIL reset_vld got %b exp 0", vld); end
        n_cmp++; if (cnt !== '0) begin n_bad++; $display("FAIL reset_cnt got %h exp 0", cnt); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", err); end
        n_cmp++; if (err3 !== 1'b0) begin n_bad++; $display("FAIL reset_err3 got %b exp 0", err3); end
        do_reset();
        @(negedge clk);
        n_cmp++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got %b exp 1", req_rdy); end
        tick();
    endtask

    task automatic test_single_write();
        txnid_t id;
        rdy = '1;
        drive(1'b1, CMD_WRITE, 2'd2);
        id = req_pld.cmd_txnid;
        @(negedge clk);
        n_cmp++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL single_rdy got %b exp 1", req_rdy); end
        tick();
        req_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (vld !== 4'b0100) begin n_bad++; $display("FAIL single_vld got %b exp 0100", vld); end
        n_cmp++; if (pld[2].txnid !== id) begin n_bad++; $display("FAIL single_txnid got %h exp %h", pld[2].txnid, id); end
        n_cmp++; if (cnt[2] !== 3'd1) begin n_bad++; $display("FAIL single_cnt1 got %0d exp 1", cnt[2]); end
        tick();
        @(negedge clk);
        n_cmp++; if (vld !== '0) begin n_bad++; $display("FAIL single_vld_after got %b exp 0", vld); end
        n_cmp++; if (cnt[2] !== 3'd0) begin n_bad++; $display("FAIL single_cnt0 got %0d exp 0", cnt[2]); end
        tick();
    endtask

    task automatic test_fill_stall();
        wr_resp_pld_t sent [5];
        rdy = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, CMD_WRITE, 2'd1);
            sent[k].txnid = req_pld.cmd_txnid;
            sent[k].sideband = req_pld.cmd_sideband;
            @(negedge clk);
            n_cmp++; if (req_rdy !== (k < 4)) begin n_bad++; $display("FAIL fill_rdy[%0d] got %b exp %b", k, req_rdy, k < 4); end
            if (k < 4) tick();
        end
        n_cmp++; if (cnt[1] !== 3'd4) begin n_bad++; $display("FAIL fill_cnt got %0d exp 4", cnt[1]); end
        tick();
        rdy[1] = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_rdy !== 1'b0) begin n_bad++; $display("FAIL fill_rdy_pop got %b exp 0", req_rdy); end
        n_cmp++; if (pld[1] !== sent[0]) begin n_bad++; $display("FAIL fill_head0 got %h exp %h", pld[1], sent[0]); end
        tick();
        @(negedge clk);
        n_cmp++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL fill_rdy_reopen got %b exp 1", req_rdy); end
        n_cmp++; if (pld[1] !== sent[1]) begin n_bad++; $display("FAIL fill_head1 got %h exp %h", pld[1], sent[1]); end
        tick();
        req_vld = 1'b0;
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (vld[1] !== 1'b1 || pld[1] !== sent[k]) begin n_bad++; $display("FAIL fill_drain[%0d] got %b/%h exp 1/%h", k, vld[1], pld[1], sent[k]); end
            tick();
        end
        @(negedge clk);
        n_cmp++; if (cnt[1] !== 3'd0) begin n_bad++; $display("FAIL fill_empty got %0d exp 0", cnt[1]); end
        tick();
    endtask

    task automatic test_isolation();
        wr_resp_pld_t h0;
        rdy = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, CMD_WRITE, 2'd0);
            tick();
        end
        h0 = mq[0][0];
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 1) drive(1'b1, CMD_READ, 2'($urandom));
            else drive(1'b1, CMD_WRITE, 2'd3);
            @(negedge clk);
            n_cmp++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL iso_rdy[%0d] got %b exp 1", k, req_rdy); end
            n_cmp++; if (pld[0] !== h0 || cnt[0] !== 3'd4) begin n_bad++; $display("FAIL iso_d0[%0d] got %h/%0d exp %h/4", k, pld[0], cnt[0], h0); end
            tick();
        end
        drive(1'b1, CMD_WRITE, 2'd0);
        @(negedge clk);
        n_cmp++; if (req_rdy !== 1'b0) begin n_bad++; $display("FAIL iso_block got %b exp 0", req_rdy); end
        req_vld = 1'b0;
        tick();
    endtask

    task automatic test_read_opcode();
        do_reset();
        rdy = '0;
        drive(1'b1, CMD_READ, 2'd1);
        @(negedge clk);
        n_cmp++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL read_rdy got %b exp 1", req_rdy); end
        tick();
        req_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (vld !== '0) begin n_bad++; $display("FAIL read_vld got %b exp 0", vld); end
        n_cmp++; if (cnt !== '0) begin n_bad++; $display("FAIL read_cnt got %h exp 0", cnt); end
        tick();
    endtask

    task automatic test_bad_dir();
        do_reset();
        rdy = '1;
        rdy3 = '1;
        drive(1'b1, CMD_WRITE, 2'd3);
        @(negedge clk);
        n_cmp++; if (req_rdy3 !== 1'b1) begin n_bad++; $display("FAIL bad_rdy got %b exp 1", req_rdy3); end
        tick();
        req_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (err3 !== 1'b1) begin n_bad++; $display("FAIL bad_err got %b exp 1", err3); end
        n_cmp++; if (vld3 !== '0) begin n_bad++; $display("FAIL bad_vld got %b exp 0", vld3); end
        tick();
        for (int k = 0; k < 20; k++) begin
            rdy = 4'($urandom);
            drive(1'($urandom), 2'($urandom), 2'($urandom_range(0, 2)));
            tick();
        end
        @(negedge clk);
        n_cmp++; if (err3 !== 1'b1) begin n_bad++; $display("FAIL bad_sticky got %b exp 1", err3); end
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (err3 !== 1'b0) begin n_bad++; $display("FAIL bad_clear got %b exp 0", err3); end
        do_reset();
    endtask

    task automatic test_push_pop_wrap();
        do_reset();
        rdy = '0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, CMD_WRITE, 2'd2);
            tick();
        end
        rdy = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, CMD_WRITE, 2'd2);
            @(negedge clk);
            n_cmp++; if (cnt[2] !== 3'd2) begin n_bad++; $display("FAIL wrap_cnt[%0d] got %0d exp 2", k, cnt[2]); end
            n_cmp++; if (pld[2] !== mq[2][0]) begin n_bad++; $display("FAIL wrap_head[%0d] got %h exp %h", k, pld[2], mq[2][0]); end
            tick();
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (vld !== '0) begin n_bad++; $display("FAIL wrap_rst_vld got %b exp 0", vld); end
        n_cmp++; if (cnt !== '0) begin n_bad++; $display("FAIL wrap_rst_cnt got %h exp 0", cnt); end
        do_reset();
        @(negedge clk);
        n_cmp++; if (vld !== '0) begin n_bad++; $display("FAIL wrap_post_vld got %b exp 0", vld); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < W; i++) rdy[i] = $urandom_range(0, 2) == 0;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0 ? CMD_WRITE : 2'($urandom), 2'($urandom));
            @(negedge clk);
            n_cmp++; if (req_rdy !== m_rdy(req_pld)) begin n_bad++; $display("FAIL rnd_rdy[%0d] got %b exp %b", k, req_rdy, m_rdy(req_pld)); end
            n_cmp++; if (vld !== m_vld()) begin n_bad++; $display("FAIL rnd_vld[%0d] got %b exp %b", k, vld, m_vld()); end
            n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL rnd_err[%0d] got %b exp %b", k, err, m_err); end
            for (int i = 0; i < W; i++) begin
                n_cmp++; if (cnt[i] !== CW'(mq[i].size())) begin n_bad++; $display("FAIL rnd_cnt[%0d][%0d] got %0d exp %0d", k, i, cnt[i], mq[i].size()); end
                if (mq[i].size() != 0) begin
                    n_cmp++; if (pld[i] !== mq[i][0]) begin n_bad++; $display("FAIL rnd_pld[%0d][%0d] got %h exp %h", k, i, pld[i], mq[i][0]); end
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_stall();
        test_isolation();
        test_read_opcode();
        test_bad_dir();
        test_push_pop_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wr_resp_direction_router.md
WR_RESP_DIRECTION_ROUTER -- requirements
Module: wr_resp_direction_router

Interface
REQ-001 Parameter WIDTH, default 4, number of response directions (1..4, bounded by the direction_id field of cmd_txnid).
REQ-002 Parameter DEPTH, default 4, entries per direction queue (power of two, >=2).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port req_vld  input  1  request valid.
REQ-006 Port req_rdy  output  1  request accepted when req_vld && req_rdy.
REQ-007 Port req_pld  input  input_req_pld_t  request payload (cmd_opcode, cmd_txnid, cmd_sideband).
REQ-008 Port v_wresp_vld  output  WIDTH  per-direction response valid.
REQ-009 Port v_wresp_rdy  input  WIDTH  per-direction response ready.
REQ-010 Port v_wresp_pld  output  wr_resp_pld_t [WIDTH]  per-direction response (txnid, sideband).
REQ-011 Port v_wresp_cnt  output  WIDTH x $clog2(DEPTH+1)  per-direction queue occupancy.
REQ-012 Port err_bad_dir  output  1  sticky flag: write request with direction_id >= WIDTH was accepted.

Function
REQ-013 Accept = req_vld && req_rdy; a write accept has cmd_opcode == `CMD_WRITE.
REQ-014 Target direction d = req_pld.cmd_txnid.direction_id.
REQ-015 req_rdy = 1 unless the request is a write, d < WIDTH, and queue d is full (cnt == DEPTH); req_rdy depends on registered occupancy only, never on v_wresp_rdy in the same cycle.
REQ-016 Non-write accepts: consumed, no queue update, no response.
REQ-017 Write accept with d < WIDTH: push {txnid = cmd_txnid, sideband = cmd_sideband} into queue d.
REQ-018 Write accept with d >= WIDTH: consumed, no push, err_bad_dir set to 1 next cycle.
REQ-019 Each direction: independent FIFO, DEPTH entries, wr/rd pointers $clog2(DEPTH) bits wrapping DEPTH-1 -> 0, occupancy counter.
REQ-020 v_wresp_vld[i] = (cnt[i] != 0); v_wresp_pld[i] = head entry of queue i, stable while vld && !rdy.
REQ-021 Pop on v_wresp_vld[i] && v_wresp_rdy[i]; head advances next cycle.
REQ-022 Latency: push in cycle N -> entry visible at output in cycle N+1 (no combinational bypass).
REQ-023 Simultaneous push and pop on the same queue: cnt unchanged, both pointers advance.
REQ-024 Push to a full queue never occurs (blocked by REQ-015); a pop in the same cycle does not open req_rdy until the next cycle.
REQ-025 Queues are independent: a full or stalled direction blocks only writes targeting it; other traffic is accepted.
REQ-026 Order per direction preserved (FIFO); no ordering between directions.
REQ-027 Unused payload bits of empty queues: don't-care, but vld held 0.

Reset
REQ-028 On rst_n low: all pointers and cnt = 0, v_wresp_vld = 0, err_bad_dir = 0; req_rdy = 1 once reset is released.
REQ-029 Reset mid-operation: queued responses are discarded; no output valid until a new push.
REQ-030 Storage arrays need not be reset.

Verification
REQ-031 Single write, d=2, all rdy=1 -> v_wresp_vld = 4'b0100 one cycle after accept, pld.txnid equals request txnid, cnt[2] 1->0.
REQ-032 Five writes to d=1 with v_wresp_rdy[1]=0, DEPTH=4 -> four accepted, req_rdy=0 on the fifth, cnt[1]=4; release rdy -> responses drain in order, fifth accepted the cycle after the first pop.
REQ-033 d=0 full and stalled, interleave writes to d=3 and reads -> d=3 and reads accepted each cycle, d=0 responses unchanged.
REQ-034 Read opcode with d=1 -> req_rdy=1, no vld on any direction, cnt unchanged.
REQ-035 WIDTH=3, write with d=3 -> accepted, no response, err_bad_dir=1 and stays 1 until reset.
REQ-036 Queue at cnt=2, simultaneous push and pop on same direction for 8 cycles -> cnt stays 2, pointers wrap, order preserved; assert rst_n low mid-sequence -> all vld 0, cnt 0 immediately.
